// File: rtl/fire_expand_ofm_writer.sv
// Captures one 64-channel pixel per sample into a 2-slot ping-pong buffer and
// drains it to the channel-major output feature-map RAM over LANES write ports.
module fire_expand_ofm_writer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHOUT = 64,
  parameter int unsigned WOUT  = 64,
  parameter int unsigned LANES = 4,
  parameter int unsigned AW    = $clog2(CHOUT * WOUT * WOUT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   layer_start,
  input  logic                   sample_in,
  input  logic [WIDTH-1:0]       ofm_in [0:CHOUT-1],
  output logic [LANES-1:0]       wr_en,
  output logic [LANES*AW-1:0]    wr_addr,
  output logic [LANES*WIDTH-1:0] wr_data,
  output logic                   ram_feedback,
  output logic                   done,
  output logic                   overflow
);

  localparam int unsigned Beats = CHOUT / LANES;
  localparam int unsigned BW    = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned NPix  = WOUT * WOUT;
  localparam int unsigned PixW  = $clog2(NPix);
  localparam int unsigned PW    = PixW + 1;
  localparam int unsigned CW    = (CHOUT > 1) ? $clog2(CHOUT) : 1;

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [1:0]             occ_q, occ_d;
  logic                   wptr_q, wptr_d;
  logic                   rptr_q, rptr_d;
  logic [PW-1:0]          cap_pix_q, cap_pix_d;
  logic [PW-1:0]          wr_pix_q, wr_pix_d;
  logic                   done_q, done_d;
  logic                   overflow_q, overflow_d;
  logic [WIDTH-1:0]       slot_data_q [2][CHOUT];
  logic [WIDTH-1:0]       slot_data_d [2][CHOUT];
  logic [PixW-1:0]        slot_pix_q [2];
  logic [PixW-1:0]        slot_pix_d [2];
  logic [LANES-1:0]       wr_en_q, wr_en_d;
  logic [LANES*AW-1:0]    wr_addr_q, wr_addr_d;
  logic [LANES*WIDTH-1:0] wr_data_q, wr_data_d;

  logic          capture, drop, emit, last;
  logic [PW-1:0] cap_base, wr_base;
  logic [CW-1:0] ch;

  assign capture = sample_in && (occ_q != 2'd2);
  assign drop    = sample_in && (occ_q == 2'd2);
  // A slot stays counted in occupancy until its last beat, so any occupancy means a beat is due.
  assign emit    = (occ_q != 2'd0);
  assign last    = emit && (beat_q == BW'(Beats - 1));

  always_comb begin
    slot_data_d = slot_data_q;
    slot_pix_d  = slot_pix_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    occ_d       = occ_q;
    beat_d      = beat_q;
    state_d     = state_q;
    cap_base    = layer_start ? '0 : cap_pix_q;
    wr_base     = layer_start ? '0 : wr_pix_q;
    cap_pix_d   = cap_base;
    wr_pix_d    = wr_base;
    done_d      = layer_start ? 1'b0 : (done_q || (wr_pix_q == PW'(NPix)));
    overflow_d  = (layer_start ? 1'b0 : overflow_q) || drop;
    wr_en_d     = '0;
    wr_addr_d   = '0;
    wr_data_d   = '0;
    ch          = '0;

    if (capture) begin
      for (int c = 0; c < int'(CHOUT); c++) begin
        slot_data_d[wptr_q][c] = ofm_in[c];
      end
      slot_pix_d[wptr_q] = cap_base[PixW-1:0];
      wptr_d             = ~wptr_q;
      cap_pix_d          = cap_base + PW'(1);
    end

    if (emit) begin
      wr_en_d = '1;
      for (int l = 0; l < int'(LANES); l++) begin
        ch = CW'(beat_q) * CW'(LANES) + CW'(l);
        wr_data_d[l*WIDTH +: WIDTH] = slot_data_q[rptr_q][ch];
        wr_addr_d[l*AW +: AW]       = AW'(ch) * AW'(NPix) + AW'(slot_pix_q[rptr_q]);
      end
      if (last) begin
        beat_d   = '0;
        rptr_d   = ~rptr_q;
        wr_pix_d = wr_base + PW'(1);
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end

    case ({capture, last})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    unique case (state_q)
      StIdle:  if (emit) state_d = (last && occ_d == 2'd0) ? StIdle : StDrain;
      StDrain: if (last && occ_d == 2'd0) state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      occ_q      <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      cap_pix_q  <= '0;
      wr_pix_q   <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      wr_en_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int s = 0; s < 2; s++) begin
        slot_pix_q[s] <= '0;
        for (int c = 0; c < int'(CHOUT); c++) begin
          slot_data_q[s][c] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      occ_q       <= occ_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cap_pix_q   <= cap_pix_d;
      wr_pix_q    <= wr_pix_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      slot_pix_q  <= slot_pix_d;
      slot_data_q <= slot_data_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign done         = done_q;
  assign overflow     = overflow_q;
  assign ram_feedback = (occ_q != 2'd0) || (state_q == StDrain);

endmodule

// File: tb/tb_fire_expand_ofm_writer.sv
// Directed bench for fire_expand_ofm_writer at default parameters
// (64 channels, 64x64 pixels, 4 lanes, 18-bit addresses).
module tb_fire_expand_ofm_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        layer_start = 1'b0;
  logic        sample_in = 1'b0;
  logic [15:0] ofm_in [0:63];
  logic [3:0]  wr_en;
  logic [71:0] wr_addr;
  logic [63:0] wr_data;
  logic        ram_feedback;
  logic        done;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic        count_en = 1'b0;
  int          lane_writes = 0;
  logic        spot_seen = 1'b0;
  logic [15:0] spot_data = 16'h0;

  always #5 clk = ~clk;

  fire_expand_ofm_writer dut (
    .clk         (clk),
    .rst         (rst),
    .layer_start (layer_start),
    .sample_in   (sample_in),
    .ofm_in      (ofm_in),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .ram_feedback(ram_feedback),
    .done        (done),
    .overflow    (overflow)
  );

  always @(negedge clk) begin
    if (count_en) begin
      lane_writes += $countones(wr_en);
      if (wr_en[0] && wr_addr[17:0] == 18'd4095) begin
        spot_seen = 1'b1;
        spot_data = wr_data[15:0];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pixel(input logic [15:0] base);
    for (int c = 0; c < 64; c++) ofm_in[c] = base + 16'(c);
  endtask

  // Expected lane vectors for beat b of a pixel whose channel c holds base+c.
  task automatic build_exp(input int b, input int pix, input logic [15:0] base,
                           output logic [71:0] ea, output logic [63:0] ed);
    for (int l = 0; l < 4; l++) begin
      ea[l*18 +: 18] = 18'((b * 4 + l) * 4096 + pix);
      ed[l*16 +: 16] = base + 16'(b * 4 + l);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_pixel(16'h0);
    repeat (3) tick();
    checks++;
    if ({wr_en, wr_addr, wr_data, ram_feedback, done, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got en=%h addr=%h data=%h fb=%b done=%b ovf=%b, expected all 0",
               wr_en, wr_addr, wr_data, ram_feedback, done, overflow);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({wr_en, wr_addr, wr_data, ram_feedback, done, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_idle: got en=%h addr=%h data=%h fb=%b done=%b ovf=%b, expected all 0",
               wr_en, wr_addr, wr_data, ram_feedback, done, overflow);
    end
  endtask

  task automatic test_single_pixel();
    logic [71:0] ea;
    logic [63:0] ed;
    set_pixel(16'h100);
    sample_in = 1'b1;
    tick();
    sample_in = 1'b0;
    checks++;
    if (wr_en !== 4'h0 || ram_feedback !== 1'b1) begin
      errors++;
      $display("FAIL single_capture: got en=%h fb=%b, expected en=0 fb=1", wr_en, ram_feedback);
    end
    for (int b = 0; b < 16; b++) begin
      tick();
      build_exp(b, 0, 16'h100, ea, ed);
      checks++;
      if (wr_en !== 4'hF || wr_addr !== ea || wr_data !== ed) begin
        errors++;
        $display("FAIL single_beat%0d: got en=%h addr=%h data=%h, expected en=f addr=%h data=%h",
                 b, wr_en, wr_addr, wr_data, ea, ed);
      end
      if (b == 14) begin
        checks++;
        if (ram_feedback !== 1'b1) begin
          errors++;
          $display("FAIL single_fb_busy: got %b, expected 1", ram_feedback);
        end
      end
    end
    tick();
    checks++;
    if (wr_en !== 4'h0 || ram_feedback !== 1'b0) begin
      errors++;
      $display("FAIL single_end: got en=%h fb=%b, expected en=0 fb=0", wr_en, ram_feedback);
    end
  endtask

  task automatic test_nominal_cadence();
    logic [71:0] ea;
    logic [63:0] ed;
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
    count_en = 1'b1;
    for (int p = 0; p < 4096; p++) begin
      if (p == 4095) begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL cadence_early_done: got %b, expected 0", done);
        end
      end
      for (int c = 0; c < 64; c++) ofm_in[c] = 16'(p + c * 3);
      sample_in = 1'b1;
      tick();
      sample_in = 1'b0;
      repeat (16) tick();
    end
    repeat (2) tick();
    count_en = 1'b0;
    checks++;
    if (lane_writes != 262144) begin
      errors++;
      $display("FAIL cadence_writes: got %0d, expected 262144", lane_writes);
    end
    checks++;
    if (overflow !== 1'b0 || done !== 1'b1 || ram_feedback !== 1'b0) begin
      errors++;
      $display("FAIL cadence_flags: got ovf=%b done=%b fb=%b, expected ovf=0 done=1 fb=0",
               overflow, done, ram_feedback);
    end
    checks++;
    if (!spot_seen || spot_data !== 16'd4095) begin
      errors++;
      $display("FAIL cadence_spot: got seen=%b data=%h, expected seen=1 data=0fff",
               spot_seen, spot_data);
    end
    // One more sample past the end of the layer wraps to pixel 0.
    set_pixel(16'h5A00);
    sample_in = 1'b1;
    tick();
    sample_in = 1'b0;
    tick();
    build_exp(0, 0, 16'h5A00, ea, ed);
    checks++;
    if (wr_en !== 4'hF || wr_addr !== ea || wr_data !== ed || done !== 1'b1) begin
      errors++;
      $display("FAIL after_done_wrap: got en=%h addr=%h data=%h done=%b, expected en=f addr=%h data=%h done=1",
               wr_en, wr_addr, wr_data, done, ea, ed);
    end
    repeat (16) tick();
  endtask

  task automatic test_back_to_back();
    logic [71:0] ea;
    logic [63:0] ed;
    for (int k = 0; k < 34; k++) begin
      if (k < 3) begin
        set_pixel(k == 0 ? 16'hA000 : (k == 1 ? 16'hB000 : 16'hC000));
        sample_in   = 1'b1;
        layer_start = (k == 0);
      end else begin
        sample_in   = 1'b0;
        layer_start = 1'b0;
      end
      tick();
      if (k >= 1 && k <= 32) begin
        build_exp((k - 1) % 16, (k - 1) / 16, (k - 1) >= 16 ? 16'hB000 : 16'hA000, ea, ed);
        checks++;
        if (wr_en !== 4'hF || wr_addr !== ea || wr_data !== ed) begin
          errors++;
          $display("FAIL b2b_beat%0d: got en=%h addr=%h data=%h, expected en=f addr=%h data=%h",
                   k - 1, wr_en, wr_addr, wr_data, ea, ed);
        end
      end
      if (k == 1 || k == 2) begin
        checks++;
        if (overflow !== (k == 2)) begin
          errors++;
          $display("FAIL b2b_overflow_k%0d: got %b, expected %b", k, overflow, k == 2);
        end
      end
      if (k == 33) begin
        checks++;
        if (wr_en !== 4'h0 || ram_feedback !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL b2b_end: got en=%h fb=%b done=%b, expected en=0 fb=0 done=0",
                   wr_en, ram_feedback, done);
        end
      end
    end
  endtask

  task automatic test_collision();
    logic [71:0] ea;
    logic [63:0] ed;
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
    for (int k = 0; k < 34; k++) begin
      if (k == 0 || k == 16) begin
        set_pixel(k == 0 ? 16'hD000 : 16'hE000);
        sample_in = 1'b1;
      end else begin
        sample_in = 1'b0;
      end
      tick();
      if (k >= 1 && k <= 32) begin
        build_exp((k - 1) % 16, (k - 1) / 16, (k - 1) >= 16 ? 16'hE000 : 16'hD000, ea, ed);
        checks++;
        if (wr_en !== 4'hF || wr_addr !== ea || wr_data !== ed) begin
          errors++;
          $display("FAIL coll_beat%0d: got en=%h addr=%h data=%h, expected en=f addr=%h data=%h",
                   k - 1, wr_en, wr_addr, wr_data, ea, ed);
        end
      end
      if (k == 16 || k == 17) begin
        checks++;
        if (ram_feedback !== 1'b1) begin
          errors++;
          $display("FAIL coll_fb_k%0d: got %b, expected 1", k, ram_feedback);
        end
      end
      if (k == 33) begin
        checks++;
        if (wr_en !== 4'h0 || ram_feedback !== 1'b0 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL coll_end: got en=%h fb=%b ovf=%b, expected en=0 fb=0 ovf=0",
                   wr_en, ram_feedback, overflow);
        end
      end
    end
  endtask

  task automatic test_mid_drain_reset();
    logic [71:0] ea;
    logic [63:0] ed;
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
    set_pixel(16'h7700);
    sample_in = 1'b1;
    tick();
    sample_in = 1'b0;
    repeat (8) tick();
    build_exp(7, 0, 16'h7700, ea, ed);
    checks++;
    if (wr_en !== 4'hF || wr_addr !== ea || wr_data !== ed) begin
      errors++;
      $display("FAIL rst_pre_beat7: got en=%h addr=%h data=%h, expected en=f addr=%h data=%h",
               wr_en, wr_addr, wr_data, ea, ed);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_data, ram_feedback, done, overflow} !== '0) begin
      errors++;
      $display("FAIL rst_async: got en=%h addr=%h data=%h fb=%b, expected all 0",
               wr_en, wr_addr, wr_data, ram_feedback);
    end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (wr_en !== 4'h0 || ram_feedback !== 1'b0) begin
      errors++;
      $display("FAIL rst_release_idle: got en=%h fb=%b, expected en=0 fb=0", wr_en, ram_feedback);
    end
    set_pixel(16'h3300);
    sample_in = 1'b1;
    tick();
    sample_in = 1'b0;
    tick();
    build_exp(0, 0, 16'h3300, ea, ed);
    checks++;
    if (wr_en !== 4'hF || wr_addr !== ea || wr_data !== ed) begin
      errors++;
      $display("FAIL rst_new_pixel: got en=%h addr=%h data=%h, expected en=f addr=%h data=%h",
               wr_en, wr_addr, wr_data, ea, ed);
    end
    repeat (16) tick();
    checks++;
    if (wr_en !== 4'h0 || ram_feedback !== 1'b0) begin
      errors++;
      $display("FAIL rst_new_end: got en=%h fb=%b, expected en=0 fb=0", wr_en, ram_feedback);
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_nominal_cadence();
    test_back_to_back();
    test_collision();
    test_mid_drain_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fire_expand_ofm_writer.md
Name: fire_expand_ofm_writer

Overview:
- Downstream consumer of the fire2/fire3 expand 1x1 stage.
- On each sample pulse it captures the 64-channel parallel output vector of one pixel into a 2-entry ping-pong buffer, then drains it to the output feature-map RAM through LANES parallel write ports.
- Holds ram_feedback high while any data is pending, so the expand stage withholds its finish signal until every pixel is in RAM.

Parameters:
- WIDTH, 16, data word width
- CHOUT, 64, channels per pixel vector; must be a multiple of LANES
- WOUT, 64, output feature-map side; pixels per layer = WOUT*WOUT
- LANES, 4, parallel RAM write ports; CHOUT/LANES must be <= 16 so a drain finishes inside the 17-cycle pixel period
- AW, $clog2(CHOUT*WOUT*WOUT) = 18, RAM address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- layer_start  in  1  one-cycle pulse; clears pixel counters, done and overflow
- sample_in  in  1  one-cycle pulse; ofm_in is valid in the same cycle
- ofm_in  in  WIDTH x [0:CHOUT-1]  unpacked array of channel results for one pixel
- wr_en  out  LANES  per-lane RAM write enable
- wr_addr  out  LANES*AW  packed; lane l occupies bits [l*AW +: AW]
- wr_data  out  LANES*WIDTH  packed; lane l occupies bits [l*WIDTH +: WIDTH]
- ram_feedback  out  1  high while any captured pixel is not yet fully written
- done  out  1  high once WOUT*WOUT pixels are written; held until layer_start
- overflow  out  1  sticky; a sample arrived while both slots were full

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, ram_feedback=0, done=0, overflow=0. Internal state: slots empty, both pointers 0, cap_pix=0, wr_pix=0, FSM in IDLE.
- Capture:
  - On a sample_in cycle with occupancy < 2, latch ofm_in and cap_pix into slot[wptr].
  - Then wptr toggles and cap_pix increments.
  - With occupancy == 2, the sample is dropped, overflow is set, and cap_pix does not advance.
- FSM states are IDLE and DRAIN.
  - IDLE -> DRAIN when occupancy > 0. beat=0, slot=rptr.
  - In DRAIN, each cycle registers one beat. For lane l: channel c = beat*LANES + l, wr_en[l]=1, wr_data lane = slot[rptr][c], wr_addr lane = c*WOUT*WOUT + pixel index of the slot (channel-major layout).
  - beat increments each cycle. On beat == CHOUT/LANES-1: rptr toggles, occupancy decrements, wr_pix increments.
  - After the last beat, go to DRAIN with beat=0 if occupancy after the update is > 0, otherwise go to IDLE.
- Outputs are registered. The first write beat appears 2 cycles after sample_in on an idle block (cycle 1: capture, cycle 2: beat 0 on outputs).
- Drain takes CHOUT/LANES cycles per pixel, i.e. 16 cycles at the defaults. Back-to-back slots drain without a bubble.
- Simultaneous capture and last-beat retire in the same cycle: occupancy is unchanged, and the new slot is valid for the next drain.
- ram_feedback = (occupancy != 0) || (state == DRAIN), computed combinationally from registered state.
- done:
  - Set on the cycle after wr_pix reaches WOUT*WOUT.
  - Further samples after done are still captured and written at pixel index modulo WOUT*WOUT; done stays high.
- layer_start:
  - Clears cap_pix, wr_pix, done and overflow.
  - If it coincides with sample_in, the capture is recorded as pixel 0.
  - Pending slots are not discarded.
- Address arithmetic is unsigned. Pixel counters are $clog2(WOUT*WOUT)+1 bits wide.
- Reset mid-drain: immediately returns all state and outputs to reset values; partial writes are abandoned.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, then release -> all outputs 0, ram_feedback=0.
- Single pixel: ofm_in[c]=c+16'h100, one sample_in -> 16 beats follow. Beat 0 is lane l: addr=l*4096, data=16'h100+l. Beat 15 lane 3: addr=63*4096=258048, data=16'h13F. ram_feedback falls the cycle after beat 15.
- Nominal cadence: 4096 samples spaced 17 cycles apart -> overflow=0, 262144 total lane writes, done=1 after the last beat. Spot-check pixel 4095 channel 0 at addr 4095.
- Back-to-back stress: 3 samples on consecutive cycles -> slots hold pixels 0 and 1, the third sample is dropped, overflow=1. Exactly 32 beats occur with no bubble between pixels, and pixel 1 writes start at beat 16.
- Capture/retire collision: second sample coincides with pixel 0's last beat -> pixel 1 drains immediately with no bubble, and occupancy never exceeds 1.
- Mid-drain reset: assert rst at beat 7 -> wr_en=0 asynchronously and ram_feedback=0. After release, a new sample is written at pixel 0.
